// File: rtl/gps_bridge_pkg.sv
// Shared types and constants for the GPS sample capture path.
// Sample bit layout, FSM state encoding and default sizing live here.
package gps_bridge_pkg;

    localparam int SAMPLE_W = 4;

    localparam int IDX_I0 = 0;
    localparam int IDX_I1 = 1;
    localparam int IDX_Q0 = 2;
    localparam int IDX_Q1 = 3;

    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int OVF_CNT_W           = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Two-bit encoding leaves spare codes; the FSM treats them as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01
    } fsm_state_e;

    function automatic sample_t pack_sample(input logic i0, input logic i1,
                                            input logic q0, input logic q1);
        sample_t s;
        s         = '0;
        s[IDX_I0] = i0;
        s[IDX_I1] = i1;
        s[IDX_Q0] = q0;
        s[IDX_Q1] = q1;
        return s;
    endfunction

endpackage

// File: rtl/gps_edge_sync.sv
// Brings the asynchronous GPS sample clock and its four data bits into the
// MCU clock domain. The clock chain has one extra stage for rise detection;
// the data chain is delay-matched so data_o belongs to the rise on rise_o.
module gps_edge_sync
    import gps_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    gps_clk_i,
    input  sample_t data_i,
    output logic    rise_o,
    output sample_t data_o
);

    logic [SYNC_STAGES:0] clk_sync_q;
    logic [SYNC_STAGES:0] clk_sync_d;
    sample_t              data_sync_q [SYNC_STAGES];
    sample_t              data_sync_d [SYNC_STAGES];

    // Next values of both shift chains.
    always_comb begin
        clk_sync_d     = {clk_sync_q[SYNC_STAGES-1:0], gps_clk_i};
        data_sync_d[0] = data_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync_d[i] = data_sync_q[i-1];
        end
    end

    // Synchroniser registers, cleared by reset so no stale edge survives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= '0;
            end
        end else begin
            clk_sync_q <= clk_sync_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= data_sync_d[i];
            end
        end
    end

    assign rise_o = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES];
    assign data_o = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gps_sample_fifo.sv
// GPS raw-sample capture FIFO feeding the SPI bridge.
// Samples are captured on synchronised GPS_CLK rises, buffered, and the head
// is presented on registered SAMPLE_* / DATAREADY outputs. Dropped samples
// set a sticky OVERFLOW flag.
// Optional build macro GPS_FIFO_OVF_COUNT_EN adds a saturating 16-bit
// OVF_COUNT output counting dropped samples.
//
// state   | meaning
// ST_IDLE | not capturing; the next rise with ENABLE=1 aligns and enters RUN
// ST_RUN  | every detected rise pushes one sample; ENABLE=0 goes back to IDLE
module gps_sample_fifo
    import gps_bridge_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              MCU_CLK_25_000,
    input  logic              RESET,
    input  logic              GPS_CLK,
    input  logic              GPS_I0,
    input  logic              GPS_I1,
    input  logic              GPS_Q0,
    input  logic              GPS_Q1,
    input  logic              ENABLE,
    input  logic              SAMPLE_ACK,
    input  logic              OVF_CLR,
    output logic              SAMPLE_I0,
    output logic              SAMPLE_I1,
    output logic              SAMPLE_Q0,
    output logic              SAMPLE_Q1,
    output logic              DATAREADY,
    output logic [ADDR_W:0]   FIFO_LEVEL,
    output logic              OVERFLOW
`ifdef GPS_FIFO_OVF_COUNT_EN
    ,
    output logic [OVF_CNT_W-1:0] OVF_COUNT
`endif
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

    logic       sync_rise;
    sample_t    sync_data;

    fsm_state_e state_q, state_d;
    logic       push_req;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    sample_t           mem_q [DEPTH];
    sample_t           head_q, head_d;
    logic              dready_q, dready_d;
    logic              ovf_q, ovf_d;

    logic fifo_empty;
    logic fifo_full;
    logic do_push;
    logic do_pop;
    logic drop;

    gps_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i     (MCU_CLK_25_000),
        .rst_i     (RESET),
        .gps_clk_i (GPS_CLK),
        .data_i    (pack_sample(GPS_I0, GPS_I1, GPS_Q0, GPS_Q1)),
        .rise_o    (sync_rise),
        .data_o    (sync_data)
    );

    // Next-state logic; the aligning rise in IDLE is deliberately not pushed.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_rise && ENABLE) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                push_req = sync_rise;
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Push/pop arbitration, pointer and level update, and next head value.
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LEVEL_FULL);

        // A pop when empty is ignored; a full FIFO still accepts a push
        // when a pop frees a slot in the same cycle.
        do_pop  = SAMPLE_ACK & ~fifo_empty;
        do_push = push_req & (~fifo_full | do_pop);
        drop    = push_req & fifo_full & ~do_pop;

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end

        // The slot being written this cycle is not in mem_q yet, so forward
        // the incoming sample when it becomes the new head.
        if (level_d == '0) begin
            head_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = sync_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        dready_d = (level_d != '0);

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO control and registered outputs.
    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            dready_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            dready_q <= dready_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage; contents need no reset because level gates visibility.
    always_ff @(posedge MCU_CLK_25_000) begin
        if (!RESET && do_push) begin
            mem_q[wr_ptr_q] <= sync_data;
        end
    end

`ifdef GPS_FIFO_OVF_COUNT_EN
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Drop counter: saturates, and a drop coinciding with a clear restarts at 1.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (OVF_CLR) begin
            ovf_cnt_d = drop ? OVF_CNT_W'(1) : '0;
        end else if (drop && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    // Drop counter register.
    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign OVF_COUNT = ovf_cnt_q;
`endif

    assign SAMPLE_I0  = head_q[IDX_I0];
    assign SAMPLE_I1  = head_q[IDX_I1];
    assign SAMPLE_Q0  = head_q[IDX_Q0];
    assign SAMPLE_Q1  = head_q[IDX_Q1];
    assign DATAREADY  = dready_q;
    assign FIFO_LEVEL = level_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_gps_sample_fifo.sv
// Self-checking bench for gps_sample_fifo: directed scenarios plus a random
// phase, checked against a queue-based reference model and scoreboard.
// Build with GPS_FIFO_OVF_COUNT_EN to also check OVF_COUNT.
module tb_gps_sample_fifo;

    localparam int DEPTH = 16;
    localparam int HALF  = 20;

    logic MCU_CLK_25_000 = 1'b0;
    logic RESET      = 1'b1;
    logic GPS_CLK    = 1'b0;
    logic GPS_I0     = 1'b0;
    logic GPS_I1     = 1'b0;
    logic GPS_Q0     = 1'b0;
    logic GPS_Q1     = 1'b0;
    logic ENABLE     = 1'b0;
    logic SAMPLE_ACK = 1'b0;
    logic OVF_CLR    = 1'b0;

    logic       SAMPLE_I0, SAMPLE_I1, SAMPLE_Q0, SAMPLE_Q1;
    logic       DATAREADY;
    logic [4:0] FIFO_LEVEL;
    logic       OVERFLOW;
`ifdef GPS_FIFO_OVF_COUNT_EN
    logic [15:0] OVF_COUNT;
`endif

    wire [3:0] sample_vec = {SAMPLE_Q1, SAMPLE_Q0, SAMPLE_I1, SAMPLE_I0};

    always #HALF MCU_CLK_25_000 = ~MCU_CLK_25_000;

    gps_sample_fifo #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .SYNC_STAGES (2)
    ) dut (
        .MCU_CLK_25_000 (MCU_CLK_25_000),
        .RESET          (RESET),
        .GPS_CLK        (GPS_CLK),
        .GPS_I0         (GPS_I0),
        .GPS_I1         (GPS_I1),
        .GPS_Q0         (GPS_Q0),
        .GPS_Q1         (GPS_Q1),
        .ENABLE         (ENABLE),
        .SAMPLE_ACK     (SAMPLE_ACK),
        .OVF_CLR        (OVF_CLR),
        .SAMPLE_I0      (SAMPLE_I0),
        .SAMPLE_I1      (SAMPLE_I1),
        .SAMPLE_Q0      (SAMPLE_Q0),
        .SAMPLE_Q1      (SAMPLE_Q1),
        .DATAREADY      (DATAREADY),
        .FIFO_LEVEL     (FIFO_LEVEL),
        .OVERFLOW       (OVERFLOW)
`ifdef GPS_FIFO_OVF_COUNT_EN
        ,
        .OVF_COUNT      (OVF_COUNT)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Rise seen at edge t is acted on at edge t+2; the first rise after
    // enabling only aligns; pops precede pushes; a push to a full FIFO
    // without a pop is dropped.
    int         m_level = 0;
    bit         m_run   = 1'b0;
    bit         m_ovf   = 1'b0;
    int         m_cnt   = 0;
    bit         m_prev  = 1'b0;
    bit         p_rise [2];
    logic [3:0] p_data [2];
    logic [3:0] exp_q [$];

    always @(posedge MCU_CLK_25_000) begin
        bit         rise_now, due, pop, push_req, dropped;
        logic [3:0] due_d;
        if (RESET) begin
            m_level = 0; m_run = 0; m_ovf = 0; m_cnt = 0; m_prev = 0;
            p_rise[0] = 0; p_rise[1] = 0;
            exp_q.delete();
        end else begin
            rise_now  = GPS_CLK && !m_prev;
            m_prev    = GPS_CLK;
            due       = p_rise[1];
            due_d     = p_data[1];
            p_rise[1] = p_rise[0];
            p_data[1] = p_data[0];
            p_rise[0] = rise_now;
            p_data[0] = {GPS_Q1, GPS_Q0, GPS_I1, GPS_I0};

            pop      = SAMPLE_ACK && (m_level > 0);
            push_req = m_run && due;
            dropped  = 0;
            if (!m_run) begin
                if (due && ENABLE) m_run = 1;
            end else if (!ENABLE) begin
                m_run = 0;
            end

            if (pop) m_level--;
            if (push_req) begin
                if (m_level < DEPTH) begin
                    m_level++;
                    exp_q.push_back(due_d);
                end else begin
                    dropped = 1;
                    m_ovf   = 1;
                    if (OVF_CLR) m_cnt = 1;
                    else if (m_cnt < 65535) m_cnt++;
                end
            end
            if (OVF_CLR && !dropped) begin
                m_ovf = 0;
                m_cnt = 0;
            end
        end
    end

    // Per-cycle status check against the model.
    always @(posedge MCU_CLK_25_000) begin
        #5;
        if (chk_en) begin
            check("level", FIFO_LEVEL, m_level);
            check("dataready", DATAREADY, (m_level > 0));
            check("overflow", OVERFLOW, m_ovf);
`ifdef GPS_FIFO_OVF_COUNT_EN
            check("ovf_count", OVF_COUNT, m_cnt);
`endif
            if (m_level > 0 && exp_q.size() > 0)
                check("head", sample_vec, exp_q[0]);
        end
    end

    // Scoreboard monitor: every accepted handshake must pop the expected sample.
    always @(negedge MCU_CLK_25_000) begin
        #5;
        if (chk_en && !RESET && SAMPLE_ACK && DATAREADY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_empty: got sample %0h expected no pop at %0t", sample_vec, $time);
            end else begin
                check("pop_data", sample_vec, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic gps_rise(input logic [3:0] d, input bit ack, input bit clr, input int lo = 3);
        @(negedge MCU_CLK_25_000);
        GPS_CLK = 1'b1;
        {GPS_Q1, GPS_Q0, GPS_I1, GPS_I0} = d;
        @(negedge MCU_CLK_25_000);
        @(negedge MCU_CLK_25_000);
        // Lands on the edge where this rise is pushed.
        if (ack) SAMPLE_ACK = 1'b1;
        if (clr) OVF_CLR = 1'b1;
        @(negedge MCU_CLK_25_000);
        SAMPLE_ACK = 1'b0;
        OVF_CLR    = 1'b0;
        GPS_CLK    = 1'b0;
        repeat (lo - 1) @(negedge MCU_CLK_25_000);
    endtask

    task automatic ack_pulse();
        @(negedge MCU_CLK_25_000);
        SAMPLE_ACK = 1'b1;
        @(negedge MCU_CLK_25_000);
        SAMPLE_ACK = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge MCU_CLK_25_000);
        OVF_CLR = 1'b1;
        @(negedge MCU_CLK_25_000);
        OVF_CLR = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge MCU_CLK_25_000);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) gps_rise(4'($urandom_range(0, 15)), 0, 0);
        settle();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && DATAREADY; i++) ack_pulse();
        settle();
        check("drain_empty", FIFO_LEVEL, 0);
    endtask

    initial begin
        int lat;
        bit found;
        #(HALF * 2 * 90000);
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;

        // Reset state
        @(posedge MCU_CLK_25_000);
        chk_en = 1'b1;
        repeat (2) @(negedge MCU_CLK_25_000);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_dready", DATAREADY, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_sample", sample_vec, 0);
        RESET = 1'b0;

        // Alignment rise, then 1,2,3 with exact DATAREADY latency
        @(negedge MCU_CLK_25_000);
        ENABLE = 1'b1;
        gps_rise(4'hF, 0, 0);
        @(negedge MCU_CLK_25_000);
        GPS_CLK = 1'b1;
        {GPS_Q1, GPS_Q0, GPS_I1, GPS_I0} = 4'h1;
        lat = 0;
        found = 0;
        for (int k = 1; k <= 6 && !found; k++) begin
            @(posedge MCU_CLK_25_000);
            #5;
            if (DATAREADY === 1'b1) begin
                lat = k;
                found = 1;
            end
        end
        check("dready_latency", lat, 3);
        @(negedge MCU_CLK_25_000);
        GPS_CLK = 1'b0;
        repeat (2) @(negedge MCU_CLK_25_000);
        gps_rise(4'h2, 0, 0);
        gps_rise(4'h3, 0, 0);
        settle();
        check("t1_level", FIFO_LEVEL, 3);
        check("t1_head", sample_vec, 4'h1);

        // Fill to 16, one more rise overflows
        fill(13);
        check("full_level", FIFO_LEVEL, 16);
        check("full_no_ovf", OVERFLOW, 0);
        gps_rise(4'h9, 0, 0);
        settle();
        check("ovf_level", FIFO_LEVEL, 16);
        check("ovf_set", OVERFLOW, 1);
`ifdef GPS_FIFO_OVF_COUNT_EN
        check("ovf_count1", OVF_COUNT, 1);
`endif
        drain();
        clr_pulse();
        settle();
        check("ovf_cleared", OVERFLOW, 0);

        // Full with simultaneous push and pop
        fill(16);
        gps_rise(4'hA, 1, 0);
        settle();
        check("fullpp_level", FIFO_LEVEL, 16);
        check("fullpp_ovf", OVERFLOW, 0);
        for (int i = 0; i < 15; i++) ack_pulse();
        settle();
        check("fullpp_last", sample_vec, 4'hA);
        drain();

        // Empty with ACK, then push coincident with ACK
        ack_pulse();
        settle();
        check("empty_ack_level", FIFO_LEVEL, 0);
        check("empty_ack_dr", DATAREADY, 0);
        gps_rise(4'h5, 1, 0);
        settle();
        check("empty_pp_level", FIFO_LEVEL, 1);
        check("empty_pp_head", sample_vec, 4'h5);
        drain();

        // Reset with level 9 and overflow set
        fill(17);
        for (int i = 0; i < 7; i++) ack_pulse();
        settle();
        check("pre_rst_level", FIFO_LEVEL, 9);
        check("pre_rst_ovf", OVERFLOW, 1);
        @(negedge MCU_CLK_25_000);
        RESET = 1'b1;
        @(posedge MCU_CLK_25_000);
        #5;
        check("mid_rst_level", FIFO_LEVEL, 0);
        check("mid_rst_dr", DATAREADY, 0);
        check("mid_rst_ovf", OVERFLOW, 0);
        check("mid_rst_sample", sample_vec, 0);
        @(negedge MCU_CLK_25_000);
        RESET = 1'b0;
        gps_rise(4'h7, 0, 0);
        settle();
        check("post_rst_align", FIFO_LEVEL, 0);
        gps_rise(4'h8, 0, 0);
        settle();
        check("post_rst_capture", FIFO_LEVEL, 1);
        check("post_rst_head", sample_vec, 4'h8);
        drain();

        // OVF_CLR coincident with a drop
        fill(16);
        gps_rise(4'hB, 0, 1);
        settle();
        check("clr_drop_ovf", OVERFLOW, 1);
`ifdef GPS_FIFO_OVF_COUNT_EN
        check("clr_drop_cnt", OVF_COUNT, 1);
`endif
        clr_pulse();
        drain();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 99);
            if (op < 55) begin
                gps_rise(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                         ($urandom_range(0, 7) == 0), $urandom_range(2, 4));
            end else if (op < 85) begin
                ack_pulse();
            end else if (op < 93) begin
                @(negedge MCU_CLK_25_000);
                ENABLE = ENABLE ? ($urandom_range(0, 2) != 0) : 1'b1;
            end else begin
                clr_pulse();
            end
        end
        @(negedge MCU_CLK_25_000);
        ENABLE = 1'b0;
        settle();
        drain();

        repeat (4) @(negedge MCU_CLK_25_000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gps_sample_fifo.md
Name: gps_sample_fifo

Overview:
- Upstream feeder for the GPS-to-MCU SPI bridge.
- Captures 4-bit raw GPS front-end samples (I0, I1, Q0, Q1) on each rising edge of the GPS sample clock, after synchronising them into the MCU_CLK_25_000 domain.
- Buffers samples in a small FIFO and presents the head sample to the bridge with a DATAREADY/SAMPLE_ACK handshake.
- Flags overflow when the bridge falls behind.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- ADDR_W, 4: log2(DEPTH).
- SYNC_STAGES, 2: synchroniser flops on GPS_CLK and data; minimum 2.

Ports:
- MCU_CLK_25_000  in  1  system clock, 25.000 MHz, sole clock.
- RESET  in  1  synchronous, active-high reset.
- GPS_CLK  in  1  asynchronous GPS sample clock; at most 6.25 MHz; each level held ≥2 MCU_CLK cycles.
- GPS_I0, GPS_I1, GPS_Q0, GPS_Q1  in  1 each  raw sample bits; stable around GPS_CLK rise.
- ENABLE  in  1  capture enable.
- SAMPLE_ACK  in  1  one-cycle pop request from the bridge.
- OVF_CLR  in  1  clears OVERFLOW.
- SAMPLE_I0, SAMPLE_I1, SAMPLE_Q0, SAMPLE_Q1  out  1 each  head-of-FIFO sample.
- DATAREADY  out  1  FIFO non-empty, registered.
- FIFO_LEVEL  out  ADDR_W+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky; a sample was dropped.

Behaviour:
- Reset: synchronous and active-high; clock and reset named MCU_CLK_25_000 and RESET. While RESET=1, all of the following are forced on each clock edge:
  - pointers = 0, FIFO_LEVEL = 0, DATAREADY = 0, OVERFLOW = 0;
  - SAMPLE_* = 0, state = IDLE;
  - synchroniser flops = 0.
- Reset mid-operation discards all buffered samples. No partial handshake survives.
- Synchroniser:
  - GPS_CLK and the four data bits pass through matched SYNC_STAGES-deep register chains, plus one extra GPS_CLK stage for edge detect.
  - rise = stage[SYNC_STAGES-1] & ~stage[SYNC_STAGES].
  - Data is taken from the delay-matched data stage.
- Control FSM, 2 states:
  - IDLE: no pushes. Go to RUN on the first detected rise while ENABLE=1. That first rise is not captured, which guarantees frame alignment.
  - RUN: every rise pushes one sample. ENABLE=0 returns to IDLE next cycle; the FIFO contents are kept and remain poppable.
  - Invalid encodings recover to IDLE.
- Latency: a GPS_CLK rise first sampled high at edge t is written at edge t+SYNC_STAGES. With SYNC_STAGES=2 and the FIFO empty, DATAREADY=1 and SAMPLE_* valid after edge t+2.
- Handshake:
  - SAMPLE_* and DATAREADY are registered outputs.
  - SAMPLE_ACK while DATAREADY=1 pops; the next head, or DATAREADY=0, is visible after the following edge.
  - SAMPLE_ACK while DATAREADY=0 is ignored. Level and pointers are unchanged.
- Simultaneous push and pop:
  - Level unchanged; both pointers advance.
  - If empty: push only; the pop is ignored.
  - If full: both occur; no overflow.
- Full with push and no pop: the new sample is dropped, OVERFLOW is set, and FIFO contents are untouched.
- OVERFLOW clear:
  - OVF_CLR clears OVERFLOW next edge.
  - An overflow event in the same cycle as OVF_CLR wins, so OVERFLOW stays 1.
- Pointers are ADDR_W bits, wrap modulo DEPTH; full/empty are derived from FIFO_LEVEL.
- FIFO_LEVEL arithmetic is unsigned and never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: GPS_FIFO_OVF_COUNT_EN.
- Defined: adds output port OVF_COUNT, 16 bits.
  - Increments once per dropped sample and saturates at 16'hFFFF.
  - Cleared by RESET and by OVF_CLR; an increment in the same cycle as OVF_CLR yields 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gps_bridge_pkg:
  - SAMPLE_W=4;
  - bit-index constants IDX_I0=0, IDX_I1=1, IDX_Q0=2, IDX_Q1=3;
  - FSM state constants ST_IDLE, ST_RUN;
  - default DEPTH.
- Sub-module gps_edge_sync: parameterised synchroniser plus rise detect. Outputs a rise pulse and the aligned 4-bit sample. The FIFO storage and FSM stay in the top.

Test Plan:
- Reset, then ENABLE=1 and a GPS_CLK at 4 MHz with samples 4'h1, 4'h2, 4'h3 after the alignment edge, and no ACK -> FIFO_LEVEL=3; head=4'h1; DATAREADY rises exactly 2 edges after the first captured rise is sampled.
- Fill 16 samples, no ACK, then one more rise -> FIFO_LEVEL=16; OVERFLOW=1; pop all 16 -> values in order with no corruption; OVF_COUNT=1 if enabled.
- FIFO full, rise and SAMPLE_ACK in the same cycle -> FIFO_LEVEL stays 16; OVERFLOW stays 0; the new sample appears last.
- FIFO empty, SAMPLE_ACK pulsed -> FIFO_LEVEL=0; DATAREADY=0; no pointer movement. Then a rise coincident with ACK -> FIFO_LEVEL=1.
- RESET asserted with FIFO_LEVEL=9 and OVERFLOW=1 -> after one edge all outputs 0 and state IDLE; the first post-reset rise is not captured.
- 70000 overflow events with GPS_FIFO_OVF_COUNT_EN -> OVF_COUNT=16'hFFFF; OVF_CLR coincident with a drop -> OVF_COUNT=1 and OVERFLOW=1.
